uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the data bits per frame; legal range 5..8.
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the FIFO entry count; power of 2, 2..256.
REQ-003 Parameter CLKS_PER_BIT, default 868, SHALL set the Clk cycles per serial bit; minimum 2.
REQ-004 Parameter PARITY, default 0, SHALL select the parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, SHALL set the stop-bit count; legal values 1 or 2.
REQ-006 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 Rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-008 send_data  input  1  SHALL be the write strobe; one FIFO push per high cycle.
REQ-009 Data_TX  input  DATA_BITS  SHALL be the byte to enqueue, sampled when send_data is high.
REQ-010 TX  output  1  SHALL be the serial line, registered, idle high.
REQ-011 is_busy  output  1  SHALL be high while the FSM is not IDLE or the FIFO is non-empty.
REQ-012 fifo_full  output  1  SHALL be high when the FIFO holds FIFO_DEPTH entries.
REQ-013 fifo_empty  output  1  SHALL be high when the FIFO holds 0 entries.
REQ-014 overflow  output  1  SHALL pulse high for one cycle when a push is dropped.

Function
REQ-015 The FIFO SHALL be circular, with head/tail pointers of log2(FIFO_DEPTH) bits wrapping modulo depth, and an occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-016 A push while full SHALL be dropped, with the FIFO unchanged and overflow=1 on the next cycle.
REQ-017 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged, including when full.
REQ-018 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop the FIFO head into the shift register, go to START, and load the baud counter, all on the same edge.
REQ-020 Each of START, DATA (per bit), PARITY and STOP (per bit) SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
REQ-021 In START, TX SHALL be 0. In DATA, TX SHALL carry the data bits LSB first, for DATA_BITS bits. In STOP, TX SHALL be 1 for STOP_BITS bits.
REQ-022 PARITY SHALL be skipped when PARITY=0. Otherwise the parity bit SHALL be the XOR of the data bits for even mode, and its inverse for odd mode.
REQ-023 After the last stop bit, the FSM SHALL return to IDLE for exactly one cycle before starting any next frame, giving back-to-back frames with a 1-cycle gap.
REQ-024 Latency: with the FIFO empty and the FSM in IDLE, a push at edge N SHALL make TX fall to 0 immediately after edge N+2 (edge N+1 pops and loads START; edge N+2 registers TX=0).
REQ-025 Writes during a frame SHALL NOT disturb the frame in flight.
REQ-026 In IDLE, TX SHALL be 1.

Reset
REQ-027 While Rst=1, outputs SHALL be forced immediately, independent of Clk: TX=1, is_busy=0, fifo_empty=1, fifo_full=0, overflow=0.
REQ-028 Reset SHALL clear the FSM to IDLE, clear the pointers, count and baud counter to 0, and discard all FIFO contents; FIFO storage need not be cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame, with TX=1 immediately and no resumption after release.
REQ-030 The first push SHALL be accepted on the first rising edge after Rst deasserts.

Verification (DATA_BITS=8, CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
REQ-031 Even parity, 1 stop: push 0xA5 -> TX = 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total; TX falls 2 edges after the push.
REQ-032 PARITY=1, STOP_BITS=2: push 0x00 -> start 0, eight 0s, parity 1, stop 1,1; 48 cycles.
REQ-033 PARITY=0: push 0x01,0x02,0x03 on consecutive cycles -> three frames of 40 cycles, 1-cycle IDLE gaps, order preserved; is_busy falls after the third stop bit.
REQ-034 Hold the FSM busy and push 5 bytes -> fifo_full=1 after the 4th; the 5th is dropped with a 1-cycle overflow pulse; only 4 bytes are transmitted.
REQ-035 With the FIFO full, push exactly on the pop edge -> the push is accepted, no overflow, fifo_full stays 1.
REQ-036 Assert Rst at the 3rd data bit of 0xFF -> TX=1 at once, is_busy=0, fifo_empty=1; after release, a push of 0x55 transmits a correct frame.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: circular FIFO feeding a start/data/parity/stop
// serialiser. TX is registered from the current state, so it trails the FSM by one cycle.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 send_data,
  input  logic [DATA_BITS-1:0] Data_TX,
  output logic                 TX,
  output logic                 is_busy,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = 3;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_DATA   = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  LAST_STOP   = IDX_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  state_t               state;
  logic [BAUD_W-1:0]    baud;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;

  logic pop;
  logic push_ok;
  logic bit_end;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = (state == S_IDLE) && !fifo_empty;
  // A full FIFO still accepts a write on the edge that frees a slot.
  assign push_ok    = send_data && (!fifo_full || pop);
  assign is_busy    = (state != S_IDLE) || !fifo_empty;
  assign bit_end    = (baud == '0);

  // FIFO storage
  always_ff @(posedge Clk) begin
    if (push_ok) mem[tail] <= Data_TX;
  end

  // FIFO control
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow <= send_data && !push_ok;
    end
  end

  // Frame data: loaded on pop, shifted LSB-first at each data-bit boundary
  always_ff @(posedge Clk) begin
    if (pop) begin
      shift   <= mem[head];
      par_bit <= parity_of(mem[head]);
    end else if (state == S_DATA && bit_end) begin
      shift <= shift >> 1;
    end
  end

  // Serialiser FSM
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      TX      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          TX <= 1'b1;
          if (pop) begin
            state <= S_START;
            baud  <= BAUD_RELOAD;
          end
        end
        S_START: begin
          TX <= 1'b0;
          if (bit_end) begin
            state   <= S_DATA;
            baud    <= BAUD_RELOAD;
            bit_idx <= '0;
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
        S_DATA: begin
          TX <= shift[0];
          if (bit_end) begin
            baud <= BAUD_RELOAD;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              state   <= (PARITY == 0) ? S_STOP : S_PARITY;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
        S_PARITY: begin
          TX <= par_bit;
          if (bit_end) begin
            state   <= S_STOP;
            baud    <= BAUD_RELOAD;
            bit_idx <= '0;
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
        S_STOP: begin
          TX <= 1'b1;
          if (bit_end) begin
            if (bit_idx == LAST_STOP) begin
              state   <= S_IDLE;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              baud    <= BAUD_RELOAD;
            end
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          TX    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (even/1 stop, odd/2 stop, no parity)
// checked cycle by cycle against frames built from the line-format rules.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic       Clk;
  logic       Rst;
  logic [2:0] send;
  logic [7:0] data [3];
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] full;
  logic [2:0] empty;
  logic [2:0] ovf;

  int n_checks = 0;
  int n_err    = 0;
  int par_of  [3] = '{2, 1, 0};
  int stop_of [3] = '{1, 2, 1};

  logic [7:0] q [5];
  logic [7:0] pb;
  logic [7:0] xb;

  uart_tx_param #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1))
    u_even (.Clk(Clk), .Rst(Rst), .send_data(send[0]), .Data_TX(data[0]), .TX(tx[0]),
            .is_busy(busy[0]), .fifo_full(full[0]), .fifo_empty(empty[0]), .overflow(ovf[0]));

  uart_tx_param #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2))
    u_odd2 (.Clk(Clk), .Rst(Rst), .send_data(send[1]), .Data_TX(data[1]), .TX(tx[1]),
            .is_busy(busy[1]), .fifo_full(full[1]), .fifo_empty(empty[1]), .overflow(ovf[1]));

  uart_tx_param #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1))
    u_none (.Clk(Clk), .Rst(Rst), .send_data(send[2]), .Data_TX(data[2]), .TX(tx[2]),
            .is_busy(busy[2]), .fifo_full(full[2]), .fifo_empty(empty[2]), .overflow(ovf[2]));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic int frame_len(input int par, input int stops);
    return 1 + 8 + ((par != 0) ? 1 : 0) + stops;
  endfunction

  // Line levels bit by bit: start, 8 data LSB first, optional parity, stops.
  function automatic logic [15:0] frame_bits(input logic [7:0] b, input int par, input int stops);
    logic [15:0] f;
    int n;
    int ones;
    f = '1;
    f[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      f[n] = b[i];
      n++;
    end
    ones = $countones(b);
    if (par == 2) f[n] = ((ones % 2) == 1);
    else if (par == 1) f[n] = ((ones % 2) == 0);
    return f;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    send[d] = 1'b1;
    data[d] = b;
    @(negedge Clk);
    send[d] = 1'b0;
  endtask

  task automatic check_frame(input int d, input logic [7:0] b, input int wait_max);
    logic [15:0] f;
    int len;
    int waited;
    f = frame_bits(b, par_of[d], stop_of[d]);
    len = frame_len(par_of[d], stop_of[d]) * CPB;
    waited = 0;
    while (tx[d] !== 1'b0 && waited < wait_max) begin
      @(negedge Clk);
      waited++;
    end
    chk($sformatf("d%0d start of 0x%02h", d, b), tx[d], 1'b0);
    for (int i = 1; i < len; i++) begin
      @(negedge Clk);
      chk($sformatf("d%0d byte 0x%02h cycle %0d", d, b, i), tx[d], f[i / CPB]);
      if (i == len - 2) chk($sformatf("d%0d busy in stop 0x%02h", d, b), busy[d], 1'b1);
    end
  endtask

  task automatic gap_frame(input int d, input logic [7:0] b);
    @(negedge Clk);
    chk($sformatf("d%0d idle gap before 0x%02h", d, b), tx[d], 1'b1);
    @(negedge Clk);
    check_frame(d, b, 0);
  endtask

  task automatic push_check_latency(input int d, input logic [7:0] b);
    push(d, b);
    chk($sformatf("d%0d tx high after push edge", d), tx[d], 1'b1);
    @(negedge Clk);
    chk($sformatf("d%0d tx high after pop edge", d), tx[d], 1'b1);
    @(negedge Clk);
    check_frame(d, b, 0);
  endtask

  task automatic chk_quiet(input int d, input int cycles, input string tag);
    logic quiet;
    quiet = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (tx[d] !== 1'b1 || busy[d] !== 1'b0) quiet = 1'b0;
    end
    chk(tag, quiet, 1'b1);
  endtask

  initial begin
    Rst = 1'b1;
    send = '0;
    for (int i = 0; i < 3; i++) data[i] = '0;

    // Outputs under reset, before any clock edge
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d reset tx", d), tx[d], 1'b1);
      chk($sformatf("d%0d reset busy", d), busy[d], 1'b0);
      chk($sformatf("d%0d reset empty", d), empty[d], 1'b1);
      chk($sformatf("d%0d reset full", d), full[d], 1'b0);
      chk($sformatf("d%0d reset overflow", d), ovf[d], 1'b0);
    end
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    // Even parity 0xA5 with two-edge latency
    push_check_latency(0, 8'hA5);
    @(negedge Clk);
    chk("d0 busy after A5", busy[0], 1'b0);
    chk("d0 empty after A5", empty[0], 1'b1);

    // Random single frames on even and odd/2-stop
    for (int r = 0; r < 3; r++) begin
      push_check_latency(0, 8'($urandom));
      @(negedge Clk);
      push_check_latency(1, 8'($urandom));
      @(negedge Clk);
    end

    // Odd parity, two stops, all-zero data
    push_check_latency(1, 8'h00);
    @(negedge Clk);

    // No parity: three consecutive pushes, back-to-back frames
    for (int i = 0; i < 3; i++) q[i] = 8'($urandom);
    push(2, q[0]);
    push(2, q[1]);
    push(2, q[2]);
    check_frame(2, q[0], 4);
    gap_frame(2, q[1]);
    gap_frame(2, q[2]);
    chk("d2 busy falls after third frame", busy[2], 1'b0);
    @(negedge Clk);
    chk("d2 empty after third frame", empty[2], 1'b1);
    chk("d2 tx idle after third frame", tx[2], 1'b1);
    @(negedge Clk);

    // Overflow: one frame in flight, then five pushes into a depth-4 FIFO
    pb = 8'($urandom);
    for (int i = 0; i < 5; i++) q[i] = 8'($urandom);
    push(2, pb);
    fork
      begin
        check_frame(2, pb, 8);
        for (int i = 0; i < 4; i++) gap_frame(2, q[i]);
        chk_quiet(2, 60, "d2 dropped byte not sent");
      end
      begin
        push(2, q[0]);
        push(2, q[1]);
        push(2, q[2]);
        chk("d2 not full after 3", full[2], 1'b0);
        push(2, q[3]);
        chk("d2 full after 4", full[2], 1'b1);
        chk("d2 no overflow after 4", ovf[2], 1'b0);
        push(2, q[4]);
        chk("d2 overflow pulse", ovf[2], 1'b1);
        chk("d2 still full after drop", full[2], 1'b1);
        @(negedge Clk);
        chk("d2 overflow one cycle", ovf[2], 1'b0);
        chk("d2 full after pulse", full[2], 1'b1);
      end
    join
    @(negedge Clk);

    // Full FIFO, push exactly on the pop edge
    pb = 8'($urandom);
    xb = 8'($urandom);
    for (int i = 0; i < 4; i++) q[i] = 8'($urandom);
    push(0, pb);
    fork
      begin
        check_frame(0, pb, 8);
        send[0] = 1'b1;
        data[0] = xb;
        @(negedge Clk);
        send[0] = 1'b0;
        chk("d0 no overflow on pop-edge push", ovf[0], 1'b0);
        chk("d0 full kept on pop-edge push", full[0], 1'b1);
        chk("d0 idle gap at pop edge", tx[0], 1'b1);
        @(negedge Clk);
        check_frame(0, q[0], 0);
        for (int i = 1; i < 4; i++) gap_frame(0, q[i]);
        gap_frame(0, xb);
        chk("d0 busy falls after drain", busy[0], 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) push(0, q[i]);
        chk("d0 full while frame in flight", full[0], 1'b1);
      end
    join
    @(negedge Clk);

    // Reset during the third data bit, with another byte queued
    send[0] = 1'b1; data[0] = 8'hFF;
    send[1] = 1'b1; data[1] = 8'h00;
    @(negedge Clk);
    data[0] = 8'h3C;
    data[1] = 8'hC3;
    @(negedge Clk);
    send[0] = 1'b0;
    send[1] = 1'b0;
    for (int w = 0; w < 8 && tx[1] !== 1'b0; w++) @(negedge Clk);
    chk("d1 start seen before reset", tx[1], 1'b0);
    repeat (13) @(negedge Clk);
    chk("d1 in zero data bit before reset", tx[1], 1'b0);
    #1 Rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d mid-frame reset tx", d), tx[d], 1'b1);
      chk($sformatf("d%0d mid-frame reset busy", d), busy[d], 1'b0);
      chk($sformatf("d%0d mid-frame reset empty", d), empty[d], 1'b1);
      chk($sformatf("d%0d mid-frame reset full", d), full[d], 1'b0);
      chk($sformatf("d%0d mid-frame reset overflow", d), ovf[d], 1'b0);
    end
    @(negedge Clk);
    chk("d1 tx held in reset", tx[1], 1'b1);
    Rst = 1'b0;
    fork
      push_check_latency(0, 8'h55);
      chk_quiet(1, 60, "d1 no resumption after reset");
    join
    @(negedge Clk);
    chk("d0 empty at end", empty[0], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
